// File: rtl/popcount_expander.sv
// -----------------------------------------------------------------------------
// popcount_expander
//
// Turns a requested count into a WIDTH-bit vector holding exactly
// min(count, WIDTH) ones, setting one bit per clock. The first bit lands at a
// rotating start position (offset) that advances after every delivered result,
// so successive transactions walk the ones across every output position.
//
// Ports
//   clk        in   1      clock, rising edge
//   rst        in   1      synchronous, active-high reset
//   in_valid   in   1      in_count is valid
//   in_ready   out  1      block can accept a count (IDLE and not in reset)
//   in_count   in   CW     requested number of ones
//   out_valid  out  1      out_vec/out_sat hold a completed result
//   out_ready  in   1      consumer accepts the result
//   out_vec    out  WIDTH  vector with min(in_count, WIDTH) ones
//   out_sat    out  1      request exceeded WIDTH and was clipped
//   busy       out  1      FSM not in IDLE
// -----------------------------------------------------------------------------
module popcount_expander #(
  parameter int WIDTH = 6,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CW-1:0]    in_count,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_vec,
  output logic             out_sat,
  output logic             busy
);

  // Width of a bit position inside out_vec.
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [CW-1:0] WIDTH_CNT = CW'(WIDTH);
  localparam logic [IW-1:0] LAST_POS  = IW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUILD,
    OUT
  } state_t;

  state_t           state, state_next;
  logic [CW-1:0]    rem,    rem_next;     // ones still to place
  logic [IW-1:0]    idx,    idx_next;     // position of the next one
  logic [IW-1:0]    offset, offset_next;  // start position of the next transaction
  logic [WIDTH-1:0] vec,    vec_next;
  logic             sat,    sat_next;

  // Advance a bit position, wrapping from WIDTH-1 back to 0.
  function automatic logic [IW-1:0] next_pos(input logic [IW-1:0] pos);
    return (pos == LAST_POS) ? '0 : pos + 1'b1;
  endfunction

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == OUT);
  assign busy      = (state != IDLE);
  assign out_vec   = vec;
  assign out_sat   = sat;

  // NOTE: every signal is given its hold value before the case statement, so
  // each path through the block assigns it and no latch is inferred; blocking
  // assignments are correct here because this block is purely combinational.
  always_comb begin
    state_next  = state;
    rem_next    = rem;
    idx_next    = idx;
    offset_next = offset;
    vec_next    = vec;
    sat_next    = sat;

    unique case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          // Clip the request to the vector width and flag the overflow.
          rem_next   = (in_count > WIDTH_CNT) ? WIDTH_CNT : in_count;
          sat_next   = (in_count > WIDTH_CNT);
          vec_next   = '0;
          idx_next   = offset;
          state_next = BUILD;
        end
      end

      BUILD: begin
        if (rem != '0) begin
          vec_next[idx] = 1'b1;
          idx_next      = next_pos(idx);
          rem_next      = rem - 1'b1;
        end
        // The last one is placed on the same edge that leaves BUILD; a zero
        // count spends a single cycle here and delivers an all-zero vector.
        if (rem <= CW'(1)) begin
          state_next = OUT;
        end
      end

      OUT: begin
        // Result holds until accepted; the start position moves on only when
        // the result is actually consumed.
        if (out_ready) begin
          offset_next = next_pos(offset);
          state_next  = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // NOTE: the whole state is reset (there is no storage array here), so out_vec
  // is never X, and a reset mid-transaction discards the result and offset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      rem    <= '0;
      idx    <= '0;
      offset <= '0;
      vec    <= '0;
      sat    <= 1'b0;
    end else begin
      state  <= state_next;
      rem    <= rem_next;
      idx    <= idx_next;
      offset <= offset_next;
      vec    <= vec_next;
      sat    <= sat_next;
    end
  end

endmodule
